// File: rtl/audio_gain_ramp_pkg.sv
// Shared definitions for the audio gain stage: widths, FSM states and the
// fixed-point helpers (dequantize matches the de-emphasis stage rounding).
package audio_gain_ramp_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int GAIN_WIDTH = 16;
  localparam int BITS       = 10;
  localparam int OUT_SHIFT  = 4;
  localparam int PROD_WIDTH = DATA_WIDTH + GAIN_WIDTH + 1;
  localparam int QUANT_VAL  = 1 << BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    OUT  = 2'd2
  } state_t;

  typedef logic signed [PROD_WIDTH-1:0] prod_t;

  // Truncate toward zero: bias negative values before the arithmetic shift.
  function automatic prod_t dequantize(input prod_t p);
    prod_t bias;
    bias = p[PROD_WIDTH-1] ? prod_t'(QUANT_VAL - 1) : '0;
    return (p + bias) >>> BITS;
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] saturate(input prod_t s);
    prod_t sat_max;
    prod_t sat_min;
    sat_max = '0;
    sat_max[DATA_WIDTH-2:0] = '1;
    sat_min = '1;
    sat_min[DATA_WIDTH-2:0] = '0;
    if (s > sat_max) begin
      return sat_max[DATA_WIDTH-1:0];
    end else if (s < sat_min) begin
      return sat_min[DATA_WIDTH-1:0];
    end
    return s[DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/audio_gain_ramp_if.sv
// FIFO-side signals of the gain stage: pop from the input FIFO, push to the
// output FIFO. master is the gain stage, slave is the FIFO pair.
interface audio_gain_ramp_if;
  import audio_gain_ramp_pkg::*;

  // Handshake: in_rd_en pops in_dout in the same cycle it is asserted and is
  // only raised while in_empty is low; out_wr_en pushes out_din in the cycle
  // it is asserted and is only raised while out_full is low.
  logic                  in_rd_en;
  logic                  in_empty;
  logic [DATA_WIDTH-1:0] in_dout;
  logic                  out_wr_en;
  logic                  out_full;
  logic [DATA_WIDTH-1:0] out_din;

  modport master (
    output in_rd_en,
    input  in_empty,
    input  in_dout,
    output out_wr_en,
    input  out_full,
    output out_din
  );

  modport slave (
    input  in_rd_en,
    output in_empty,
    output in_dout,
    input  out_wr_en,
    output out_full,
    input  out_din
  );

endinterface

// File: rtl/audio_gain_ramp_gain_ramp.sv
// Current-gain register that slews toward a target by at most RAMP_STEP each
// time step_en is pulsed, landing exactly on the target when within reach.
module gain_ramp
  import audio_gain_ramp_pkg::*;
#(
  parameter logic [GAIN_WIDTH-1:0] RAMP_STEP  = 16'h0040,
  parameter logic [GAIN_WIDTH-1:0] RESET_GAIN = 16'h0400
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  step_en,
  input  logic [GAIN_WIDTH-1:0] tgt,
  output logic [GAIN_WIDTH-1:0] cur_gain
);

  logic [GAIN_WIDTH-1:0] next_gain;

  // The +/- step is only taken when the distance exceeds it, so no wrap.
  always_comb begin
    next_gain = cur_gain;
    if (tgt >= cur_gain) begin
      if ((tgt - cur_gain) <= RAMP_STEP) next_gain = tgt;
      else                               next_gain = cur_gain + RAMP_STEP;
    end else begin
      if ((cur_gain - tgt) <= RAMP_STEP) next_gain = tgt;
      else                               next_gain = cur_gain - RAMP_STEP;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_gain <= RESET_GAIN;
    end else if (step_en) begin
      cur_gain <= next_gain;
    end
  end

endmodule

// File: rtl/audio_gain_ramp.sv
// Final audio stage: pops a sample, scales it by the ramped Q10 gain,
// dequantizes, applies output headroom shift, saturates and pushes it out.
module audio_gain_ramp
  import audio_gain_ramp_pkg::*;
#(
  parameter logic [GAIN_WIDTH-1:0] RAMP_STEP  = 16'h0040,
  parameter logic [GAIN_WIDTH-1:0] RESET_GAIN = 16'h0400
) (
  input  logic                  clock,
  input  logic                  reset,
  audio_gain_ramp_if.master     bus,
  input  logic [GAIN_WIDTH-1:0] volume,
  input  logic                  mute,
  output logic [GAIN_WIDTH-1:0] cur_gain,
  output state_t                state
);

  logic                         pop;
  logic [GAIN_WIDTH-1:0]        tgt;
  logic signed [DATA_WIDTH-1:0] x_r;
  logic [GAIN_WIDTH-1:0]        g_r;
  prod_t                        p_r;
  prod_t                        x_ext;
  prod_t                        g_ext;
  prod_t                        shifted;

  assign tgt   = mute ? '0 : volume;
  assign pop   = reset && (state == IDLE) && !bus.in_empty;
  assign x_ext = {{(PROD_WIDTH-DATA_WIDTH){x_r[DATA_WIDTH-1]}}, x_r};
  assign g_ext = {{(PROD_WIDTH-GAIN_WIDTH){1'b0}}, g_r};

  assign bus.in_rd_en  = pop;
  assign bus.out_wr_en = (state == OUT) && !bus.out_full;

  // out_din is a pure function of p_r, which only loads in MUL, so it holds
  // steady for the whole OUT state including any back-pressure stall.
  assign shifted     = dequantize(p_r) <<< OUT_SHIFT;
  assign bus.out_din = saturate(shifted);

  gain_ramp #(
    .RAMP_STEP  (RAMP_STEP),
    .RESET_GAIN (RESET_GAIN)
  ) u_gain_ramp (
    .clock    (clock),
    .reset    (reset),
    .step_en  (pop),
    .tgt      (tgt),
    .cur_gain (cur_gain)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      x_r   <= '0;
      g_r   <= '0;
      p_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            x_r   <= bus.in_dout;
            g_r   <= cur_gain;
            state <= MUL;
          end
        end
        MUL: begin
          p_r   <= x_ext * g_ext;
          state <= OUT;
        end
        OUT: begin
          if (!bus.out_full) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_gain_ramp.sv
// Randomized and directed bench for audio_gain_ramp against an arithmetic
// model of gain ramping, truncating dequantize, headroom shift and saturation.
module tb_audio_gain_ramp;
  import audio_gain_ramp_pkg::*;

  localparam int STEP    = 'h100;
  localparam int RESET_G = 'h400;

  logic                  clock;
  logic                  reset;
  logic [GAIN_WIDTH-1:0] volume;
  logic                  mute;
  logic [GAIN_WIDTH-1:0] cur_gain;
  state_t                dut_state;

  audio_gain_ramp_if bus ();

  audio_gain_ramp #(
    .RAMP_STEP  (16'(STEP)),
    .RESET_GAIN (16'(RESET_G))
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus.master),
    .volume   (volume),
    .mute     (mute),
    .cur_gain (cur_gain),
    .state    (dut_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_pops   = 0;
  int n_writes = 0;
  int m_gain   = RESET_G;
  bit gain_chk = 0;
  bit pop_now  = 0;
  bit full_seen = 0;
  bit rand_full = 0;
  bit full_req  = 0;
  logic [DATA_WIDTH-1:0] exp_q[$];
  int                    pop_q[$];
  logic [DATA_WIDTH-1:0] in_q[$];
  logic [DATA_WIDTH-1:0] last_out = '0;

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // reference model
  function automatic logic [DATA_WIDTH-1:0] model_scale(input logic [DATA_WIDTH-1:0] x, input int g);
    longint p, q, s;
    p = longint'($signed(x)) * longint'(g);
    q = p / 1024;
    s = q * 16;
    if (s > 64'sd2147483647)  s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    return 32'(s);
  endfunction

  function automatic int model_next_gain(input int cur, input int tgt);
    int d;
    d = tgt - cur;
    if (d <= STEP && d >= -STEP) return tgt;
    return (d > 0) ? cur + STEP : cur - STEP;
  endfunction

  // input/output FIFO driver
  initial begin
    bus.in_empty = 1'b1;
    bus.in_dout  = '0;
    bus.out_full = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (pop_now) begin
        void'(in_q.pop_front());
        pop_now = 0;
      end
      bus.in_empty = (in_q.size() == 0);
      bus.in_dout  = (in_q.size() != 0) ? in_q[0] : '0;
      bus.out_full = rand_full ? ($urandom_range(0, 3) == 0) : full_req;
    end
  end

  // scoreboard / monitor
  always @(negedge clock) begin
    cyc++;
    if (!reset) begin
      check("rst_wr_en", bus.out_wr_en, 0);
      check("rst_rd_en", bus.in_rd_en, 0);
      check("rst_gain", cur_gain, RESET_G);
      check("rst_out_din", bus.out_din, 0);
      check("rst_state", dut_state, IDLE);
      exp_q.delete();
      pop_q.delete();
      m_gain   = RESET_G;
      gain_chk = 0;
    end else begin
      if (gain_chk) begin
        check("cur_gain", cur_gain, m_gain);
        gain_chk = 0;
      end
      if (bus.out_wr_en) begin
        n_writes++;
        last_out = bus.out_din;
        if (exp_q.size() == 0) begin
          check("spurious_write", 1, 0);
        end else begin
          check("out_din", bus.out_din, exp_q[0]);
          if (!full_seen) check("latency", cyc - pop_q[0], 2);
          void'(exp_q.pop_front());
          void'(pop_q.pop_front());
        end
      end else if (exp_q.size() != 0 && (cyc - pop_q[0]) >= 2) begin
        full_seen = 1;
        check("stall_full", bus.out_full, 1);
        check("stall_din", bus.out_din, exp_q[0]);
        check("stall_rd_en", bus.in_rd_en, 0);
      end
      if (bus.in_rd_en) begin
        check("single_flight", exp_q.size(), 0);
        if (in_q.size() == 0) begin
          check("rd_when_empty", 1, 0);
        end else begin
          exp_q.push_back(model_scale(in_q[0], m_gain));
          pop_q.push_back(cyc);
          m_gain    = model_next_gain(m_gain, mute ? 0 : int'(volume));
          gain_chk  = 1;
          pop_now   = 1;
          full_seen = 0;
          n_pops++;
        end
      end
    end
  end

  // driver tasks
  task automatic wait_drain(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clock);
      if (in_q.size() == 0 && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 0, 1);
    #1;
  endtask

  task automatic wait_pop(input int p0);
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clock);
      if (n_pops != p0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("pop_timeout", 0, 1);
  endtask

  task automatic push_one(input logic [DATA_WIDTH-1:0] x);
    in_q.push_back(x);
    wait_drain(100);
  endtask

  task automatic set_gain(input int tgt);
    volume = 16'(tgt);
    mute   = 1'b0;
    for (int i = 0; i < 80 && m_gain != tgt; i++) push_one('0);
  endtask

  initial begin
    int w0, p0, e;
    logic [DATA_WIDTH-1:0] d;
    volume = 16'h0400;
    mute   = 1'b0;
    reset  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;

    push_one(32'h0000_1234);
    check("basic_out", last_out, 32'h0001_2340);

    set_gain('h155);
    push_one(32'hFFFF_FFFD);
    check("neg_trunc_out", last_out, 32'h0000_0000);

    set_gain('h800);
    push_one(32'h7FFF_FFFF);
    check("sat_pos", last_out, 32'h7FFF_FFFF);
    push_one(32'h8000_0000);
    check("sat_neg", last_out, 32'h8000_0000);

    set_gain('h400);
    volume = 16'h0800;
    for (int k = 0; k < 5; k++) begin
      push_one(32'(32'h100 * (k + 1)));
      e = 'h500 + 'h100 * k;
      if (e > 'h800) e = 'h800;
      check("ramp_gain", cur_gain, e);
    end
    mute = 1'b1;
    for (int k = 0; k < 9; k++) begin
      push_one(32'h0000_1000);
      e = 'h800 - 'h100 * (k + 1);
      if (e < 0) e = 0;
      check("mute_gain", cur_gain, e);
    end
    check("mute_out", last_out, 32'h0000_0000);

    set_gain('h400);
    full_req = 1;
    w0 = n_writes;
    p0 = n_pops;
    in_q.push_back(32'h0000_5555);
    in_q.push_back(32'h0000_0AAA);
    wait_pop(p0);
    repeat (7) @(posedge clock);
    #1;
    check("stall_no_write", n_writes - w0, 0);
    full_req = 0;
    wait_drain(100);
    check("stall_writes", n_writes - w0, 2);

    volume = 16'h0800;
    p0 = n_pops;
    in_q.push_back(32'h0000_2222);
    wait_pop(p0);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    w0 = n_writes;
    repeat (4) @(posedge clock);
    #1;
    check("no_stale_write", n_writes - w0, 0);
    check("gain_after_reset", cur_gain, RESET_G);
    volume = 16'h0400;
    push_one(32'h0000_0100);
    check("after_reset_out", last_out, 32'h0000_1000);

    rand_full = 1;
    for (int i = 0; i < 60; i++) begin
      for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
        case ($urandom_range(0, 3))
          0: d = $urandom;
          1: d = 32'h7FFF_FFFF - $urandom_range(0, 100);
          2: d = 32'h8000_0000 + $urandom_range(0, 100);
          default: d = $urandom_range(0, 'hFFFF) - 32'h8000;
        endcase
        in_q.push_back(d);
      end
      if ($urandom_range(0, 2) == 0) volume = 16'($urandom_range(0, 'hFFFF));
      mute = ($urandom_range(0, 5) == 0);
      wait_drain(300);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock);
        #1;
      end
    end
    rand_full = 0;
    wait_drain(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
